// File: rtl/demux_4_stream.sv
// demux_4_stream: routes one valid/ready stream to four channels; the route is held for a whole packet.
// Latency: an accepted beat appears in its channel's holding slot on the next cycle.
// Backpressure: in_ready follows only the destination slot. Other channels drain independently.
module demux_4_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic [1:0]           sel,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_last,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [4*CNT_W-1:0]   beat_cnt,
  output logic                 busy
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] cur_sel;
  logic [1:0] dest;
  logic [3:0] slot_free;
  logic       accept;

  // A slot can take a new beat when it is empty or is being drained this cycle.
  assign slot_free = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;

  // State register; the packet's destination is latched on the first beat of a multi-beat packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cur_sel <= 2'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && accept && !in_last)
        cur_sel <= sel;
    end
  end

  // Next-state logic: lock on a non-final first beat, unlock when the final beat is accepted.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && !in_last) next_state = LOCKED;
      LOCKED:  if (accept && in_last)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: the route comes from sel only between packets. in_ready never looks at in_valid.
  always_comb begin
    dest     = (state == IDLE) ? sel : cur_sel;
    in_ready = slot_free[dest];
    busy     = (state == LOCKED);
  end

  // Per-channel holding slots and saturating beat counters. Data and last hold their values after a drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 4'b0000;
      out_last  <= 4'b0000;
      out_data  <= '0;
      beat_cnt  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && dest == 2'(k)) begin
          out_data[k*WIDTH +: WIDTH] <= in_data;
          out_last[k]                <= in_last;
          out_valid[k]               <= 1'b1;
          if (beat_cnt[k*CNT_W +: CNT_W] != {CNT_W{1'b1}})
            beat_cnt[k*CNT_W +: CNT_W] <= beat_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_4_stream.sv
// Directed bench for demux_4_stream, built with 2-bit counters so that saturation is reachable.
// Inputs are driven on the falling edge. in_ready is sampled before the rising edge.
// Registered outputs are sampled 1 time unit after the rising edge.
module tb_demux_4_stream;
  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [1:0]    sel;
  logic [4*W-1:0] out_data;
  logic [3:0]    out_last;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [4*CW-1:0] beat_cnt;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  demux_4_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .beat_cnt(beat_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic       il;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] ordy;
    logic       e_rdy;
    logic [3:0] e_ov;
    logic       e_busy;
    logic [7:0] e_cnt;
    logic [1:0] ch;
    logic [7:0] e_dat;
    logic       e_last;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic iv, input logic il, input logic [1:0] s, input logic [7:0] d,
                              input logic [3:0] ordy, input logic e_rdy, input logic [3:0] e_ov,
                              input logic e_busy, input logic [7:0] e_cnt, input logic [1:0] ch,
                              input logic [7:0] e_dat, input logic e_last);
    vec_t v;
    v.iv = iv; v.il = il; v.s = s; v.d = d; v.ordy = ordy; v.e_rdy = e_rdy; v.e_ov = e_ov;
    v.e_busy = e_busy; v.e_cnt = e_cnt; v.ch = ch; v.e_dat = e_dat; v.e_last = e_last;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic il, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] ordy);
    in_valid  = iv;
    in_last   = il;
    sel       = s;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    //           iv il sel data  ordy     rdy ov       busy cnt    ch  data  last
    // Single-beat packets, one per channel.
    tbl[0]  = mk(1, 1, 2'd0, 8'hA0, 4'b1111, 1, 4'b0001, 0, 8'h01, 0, 8'hA0, 1);
    tbl[1]  = mk(1, 1, 2'd1, 8'hA1, 4'b1111, 1, 4'b0010, 0, 8'h05, 1, 8'hA1, 1);
    tbl[2]  = mk(1, 1, 2'd2, 8'hA2, 4'b1111, 1, 4'b0100, 0, 8'h15, 2, 8'hA2, 1);
    tbl[3]  = mk(1, 1, 2'd3, 8'hA3, 4'b1111, 1, 4'b1000, 0, 8'h55, 3, 8'hA3, 1);
    // Three-beat packet to ch2; sel moves to 1 mid-packet and must be ignored.
    tbl[4]  = mk(1, 0, 2'd2, 8'h11, 4'b1111, 1, 4'b0100, 1, 8'h65, 2, 8'h11, 0);
    tbl[5]  = mk(1, 0, 2'd1, 8'h22, 4'b1111, 1, 4'b0100, 1, 8'h75, 2, 8'h22, 0);
    tbl[6]  = mk(1, 1, 2'd1, 8'h33, 4'b1111, 1, 4'b0100, 0, 8'h75, 2, 8'h33, 1);
    tbl[7]  = mk(0, 0, 2'd0, 8'h00, 4'b1111, 1, 4'b0000, 0, 8'h75, 2, 8'h33, 1);
    // ch1 stalled: the first beat is held, the second is refused, and ch3 still flows.
    tbl[8]  = mk(1, 1, 2'd1, 8'hB1, 4'b1101, 1, 4'b0010, 0, 8'h79, 1, 8'hB1, 1);
    tbl[9]  = mk(1, 1, 2'd1, 8'hB2, 4'b1101, 0, 4'b0010, 0, 8'h79, 1, 8'hB1, 1);
    tbl[10] = mk(1, 1, 2'd3, 8'hC3, 4'b1101, 1, 4'b1010, 0, 8'hB9, 3, 8'hC3, 1);
    // ch1 released: drain and refill in the same cycle, so out_valid[1] has no gap.
    tbl[11] = mk(1, 1, 2'd1, 8'hB2, 4'b1111, 1, 4'b0010, 0, 8'hBD, 1, 8'hB2, 1);
    tbl[12] = mk(0, 0, 2'd0, 8'h00, 4'b1111, 1, 4'b0000, 0, 8'hBD, 1, 8'hB2, 1);

    reset = 1'b1;
    drive(0, 0, 2'd0, 8'h00, 4'b1111);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_last", 32'(out_last), 32'h0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].il, tbl[i].s, tbl[i].d, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d_beat_cnt", i), 32'(beat_cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_out_data", i), 32'(out_data[tbl[i].ch*W +: W]), 32'(tbl[i].e_dat));
      chk($sformatf("v%0d_out_last", i), 32'(out_last[tbl[i].ch]), 32'(tbl[i].e_last));
    end

    // Asynchronous reset after two beats of a four-beat packet to ch1.
    @(negedge clk);
    drive(1, 0, 2'd1, 8'hD1, 4'b1111);
    @(negedge clk);
    drive(1, 0, 2'd0, 8'hD2, 4'b1111);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'h1);
    chk("pre_rst_ch1_data", 32'(out_data[1*W +: W]), 32'hD2);
    @(negedge clk);
    drive(0, 0, 2'd0, 8'h00, 4'b1111);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_out_data", out_data, 32'h0);
    chk("arst_beat_cnt", 32'(beat_cnt), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    #1;
    reset = 1'b0;
    @(negedge clk);
    drive(1, 1, 2'd3, 8'hE3, 4'b1111);
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'h8);
    chk("post_rst_ch3_data", 32'(out_data[3*W +: W]), 32'hE3);
    chk("post_rst_beat_cnt", 32'(beat_cnt), 32'h40);
    chk("post_rst_busy", 32'(busy), 32'h0);

    // Five beats to ch0: the 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 1, 2'd0, 8'h50 + 8'(i), 4'b1111);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_cnt0", i), 32'(beat_cnt[1:0]), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    // Idle input with sel and in_last toggling (including unknown sel); ch0 is held full.
    for (int i = 0; i < 10; i++) begin
      logic [1:0] s;
      s = (i == 4 || i == 8) ? 2'bxx : 2'(i);
      @(negedge clk);
      drive(0, i[0], s, 8'hFF, 4'b0000);
      #1;
      if (i != 4 && i != 8)
        chk($sformatf("idle%0d_in_ready", i), 32'(in_ready), (s != 2'd0) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("idle%0d_out_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("idle%0d_beat_cnt", i), 32'(beat_cnt), 32'h43);
      chk($sformatf("idle%0d_ch0_data", i), 32'(out_data[W-1:0]), 32'h54);
      chk($sformatf("idle%0d_busy", i), 32'(busy), 32'h0);
    end

    // A single-beat packet afterwards must route by sel, showing the FSM is still idle.
    @(negedge clk);
    drive(1, 1, 2'd2, 8'h77, 4'b1111);
    @(posedge clk);
    #1;
    chk("final_out_valid", 32'(out_valid), 32'h4);
    chk("final_ch2_data", 32'(out_data[2*W +: W]), 32'h77);
    chk("final_beat_cnt", 32'(beat_cnt), 32'h53);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
